// File: rtl/mac_array_pipe_pkg.sv
// Shared constants for the fused-lane MAC array: mode encodings,
// default widths and the mode clamp helper.
package mac_array_pipe_pkg;

    // Fusion level m: lanes are grouped 2^m at a time.
    typedef enum logic [1:0] {
        MAC_SINGLE = 2'd0,
        MAC_DUAL   = 2'd1,
        MAC_QUAD   = 2'd2,
        MAC_OCTAL  = 2'd3
    } mac_mode_e;

    localparam int MAC_DEF_LANES = 4;
    localparam int MAC_DEF_MIN_W = 8;
    localparam int MAC_DEF_ACC_W = 32;

    // A group wider than the array collapses to the widest legal group.
    function automatic logic [1:0] mac_clamp_mode(input logic [1:0] mode, input int max_m);
        if (int'(mode) > max_m) begin
            return 2'(max_m);
        end
        return mode;
    endfunction

endpackage

// File: rtl/mac_array_pipe_group_unit.sv
// One fused multiply-accumulate group of G lanes. Operands and accumulator
// are the lane concatenations, higher lane more significant.
module mac_group_unit
    import mac_array_pipe_pkg::*;
#(
    parameter int G     = 1,
    parameter int MIN_W = MAC_DEF_MIN_W,
    parameter int ACC_W = MAC_DEF_ACC_W
) (
    input  logic [G*MIN_W-1:0] a,
    input  logic [G*MIN_W-1:0] b,
    input  logic [G*ACC_W-1:0] acc_in,
    input  logic               accumulate,
    output logic [G*ACC_W-1:0] result,
    output logic               carry
);

    localparam int OP_W = G * MIN_W;
    localparam int R_W  = G * ACC_W;

    logic [2*OP_W-1:0] prod;
    logic [R_W-1:0]    prod_ext;
    logic [R_W:0]      sum;

    // Full-width unsigned product, zero-extended into the accumulator width;
    // the extra sum bit is the group carry-out.
    always_comb begin
        prod     = {{OP_W{1'b0}}, a} * {{OP_W{1'b0}}, b};
        prod_ext = R_W'(prod);
        sum      = {1'b0, acc_in} + {1'b0, prod_ext};
        result   = accumulate ? sum[R_W-1:0] : prod_ext;
        carry    = accumulate & sum[R_W];
    end

endmodule

// File: rtl/mac_array_pipe.sv
// Two-stage lane-fusable MAC array. S1 registers the operand beat; S2 is the
// accumulator bank itself, so back-to-back accumulates chain with no hazard.
module mac_array_pipe
    import mac_array_pipe_pkg::*;
#(
    parameter int LANES = MAC_DEF_LANES,
    parameter int MIN_W = MAC_DEF_MIN_W,
    parameter int ACC_W = MAC_DEF_ACC_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic [LANES*MIN_W-1:0] a,
    input  logic [LANES*MIN_W-1:0] b,
    input  logic [1:0]             mode,
    input  logic                   acc,
    input  logic                   init_valid,
    input  logic [LANES*ACC_W-1:0] init_data,
    output logic [LANES*ACC_W-1:0] out,
    output logic                   out_valid,
    output logic [LANES-1:0]       ovf
);

    localparam int MAX_M = $clog2(LANES);
    localparam int A_W   = LANES * MIN_W;
    localparam int C_W   = LANES * ACC_W;

    logic             s1_valid;
    logic [A_W-1:0]   s1_a;
    logic [A_W-1:0]   s1_b;
    logic [1:0]       s1_mode;
    logic             s1_acc;

    logic [C_W-1:0]   acc_q;
    logic [C_W-1:0]   lvl_res [MAX_M+1];
    logic [LANES-1:0] lvl_cy  [MAX_M+1];
    logic [C_W-1:0]   sel_res;
    logic [LANES-1:0] sel_cy;

    // S1: capture the operand beat; mode is clamped here so S2 only sees legal levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mode  <= 2'd0;
            s1_acc   <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a    <= a;
                s1_b    <= b;
                s1_mode <= mac_clamp_mode(mode, MAX_M);
                s1_acc  <= acc;
            end
        end
    end

    // Every fusion level is computed in parallel; the lane mux picks one.
    for (genvar m = 0; m <= MAX_M; m++) begin : g_lvl
        localparam int G = 1 << m;
        logic [C_W-1:0]   res;
        logic [LANES-1:0] cy;
        for (genvar g = 0; g < LANES / G; g++) begin : g_grp
            logic carry;
            mac_group_unit #(
                .G     (G),
                .MIN_W (MIN_W),
                .ACC_W (ACC_W)
            ) u_mac (
                .a          (s1_a[g*G*MIN_W +: G*MIN_W]),
                .b          (s1_b[g*G*MIN_W +: G*MIN_W]),
                .acc_in     (acc_q[g*G*ACC_W +: G*ACC_W]),
                .accumulate (s1_acc),
                .result     (res[g*G*ACC_W +: G*ACC_W]),
                .carry      (carry)
            );
            assign cy[g*G +: G] = {G{carry}};
        end
        assign lvl_res[m] = res;
        assign lvl_cy[m]  = cy;
    end

    // Lane mux: select the result set for the beat's fusion level.
    always_comb begin
        sel_res = lvl_res[0];
        sel_cy  = lvl_cy[0];
        for (int m = 1; m <= MAX_M; m++) begin
            if (int'(s1_mode) == m) begin
                sel_res = lvl_res[m];
                sel_cy  = lvl_cy[m];
            end
        end
    end

    // S2: retire into the accumulators; an init load wins over a retiring beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            ovf       <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            if (init_valid) begin
                acc_q     <= init_data;
                ovf       <= '0;
                out_valid <= 1'b0;
            end else if (s1_valid) begin
                acc_q     <= sel_res;
                ovf       <= ovf | sel_cy;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out = acc_q;

endmodule
